// File: rtl/ncbo_csi_txq_if.sv
`default_nettype none
// ============================================================================
// ncbo_csi_txq_if : push-side and CSI transmit-side bundle of ncbo_csi_txq
// Revision 1.0
// ============================================================================
interface ncbo_csi_txq_if #(
    parameter int SRC_W  = 4,
    parameter int CMD_W  = 5,
    parameter int DATA_W = 64
);
    logic              in_val;
    logic              in_rdy;
    logic              in_sop;
    logic              in_eop;
    logic [SRC_W-1:0]  in_src;
    logic [CMD_W-1:0]  in_cmd;
    logic [DATA_W-1:0] in_data;
    logic              val_tx_to_csi;
    logic              csi_rdy;
    logic              fifo_sot;
    logic              fifo_eot;
    logic [SRC_W-1:0]  fifo_src;
    logic [CMD_W-1:0]  fifo_cmd;
    logic [DATA_W-1:0] fifo_data;

    modport master (
        output in_val, in_sop, in_eop, in_src, in_cmd, in_data, csi_rdy,
        input  in_rdy, val_tx_to_csi, fifo_sot, fifo_eot, fifo_src, fifo_cmd, fifo_data
    );

    modport slave (
        input  in_val, in_sop, in_eop, in_src, in_cmd, in_data, csi_rdy,
        output in_rdy, val_tx_to_csi, fifo_sot, fifo_eot, fifo_src, fifo_cmd, fifo_data
    );
endinterface
`default_nettype wire

// File: rtl/ncbo_csi_txq.sv
`default_nettype none
// ============================================================================
// ncbo_csi_txq : store-and-forward NCB outbound packet queue feeding CSI capture
// Revision 1.0
// ============================================================================
module ncbo_csi_txq #(
    parameter int DEPTH  = 8,
    parameter int SRC_W  = 4,
    parameter int CMD_W  = 5,
    parameter int DATA_W = 64
) (
    input  wire logic              csclk,
    input  wire logic              srst_n,
    ncbo_csi_txq_if.slave          bus,
    output logic [$clog2(DEPTH):0] pkt_cnt,
    output logic                   proto_err
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam logic [c_PW-1:0] c_FULL = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_ONE  = c_PW'(1);

    typedef enum logic [0:0] {IN_IDLE = 1'b0, IN_PKT = 1'b1}    in_state_t;
    typedef enum logic [0:0] {OUT_IDLE = 1'b0, OUT_SEND = 1'b1} out_state_t;

    in_state_t         r_in_state, w_in_state_nxt;
    out_state_t        r_out_state, w_out_state_nxt;
    logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr, w_count;
    logic [DEPTH-1:0]  r_mem_sop, r_mem_eop;
    logic [SRC_W-1:0]  r_mem_src  [DEPTH];
    logic [CMD_W-1:0]  r_mem_cmd  [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [SRC_W-1:0]  r_hdr_src;
    logic [CMD_W-1:0]  r_hdr_cmd;
    logic [c_AW-1:0]   w_wa, w_ra;
    logic              w_push, w_wr_en, w_drop, w_valid, w_pop, w_head_eop;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_wa       = r_wr_ptr[c_AW-1:0];
    assign w_ra       = r_rd_ptr[c_AW-1:0];
    assign w_head_eop = r_mem_eop[w_ra];

    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign bus.in_rdy = (w_count < c_FULL);
    assign w_push     = bus.in_val & bus.in_rdy;

    always_comb begin
        w_in_state_nxt = r_in_state;
        w_wr_en        = 1'b0;
        w_drop         = 1'b0;
        case (r_in_state)
            IN_IDLE: begin
                if (w_push) begin
                    if (bus.in_sop) begin
                        w_wr_en = 1'b1;
                        if (!bus.in_eop) w_in_state_nxt = IN_PKT;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (w_push) begin
                    if (bus.in_sop) begin
                        w_drop = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        if (bus.in_eop) w_in_state_nxt = IN_IDLE;
                    end
                end
            end
            default: w_in_state_nxt = IN_IDLE;
        endcase
    end

    // A full buffer with no complete packet must still drain, or a long packet deadlocks.
    assign w_valid = (r_out_state == OUT_IDLE) ? ((pkt_cnt != '0) || (w_count == c_FULL))
                                               : (w_count != '0);
    assign w_pop   = w_valid & bus.csi_rdy;

    always_comb begin
        w_out_state_nxt = r_out_state;
        case (r_out_state)
            OUT_IDLE: if (w_pop && !w_head_eop) w_out_state_nxt = OUT_SEND;
            OUT_SEND: if (w_pop && w_head_eop)  w_out_state_nxt = OUT_IDLE;
            default:  w_out_state_nxt = OUT_IDLE;
        endcase
    end

    assign bus.val_tx_to_csi = w_valid;
    assign bus.fifo_sot      = w_valid & r_mem_sop[w_ra];
    assign bus.fifo_eot      = w_valid & w_head_eop;
    assign bus.fifo_data     = w_valid ? r_mem_data[w_ra] : '0;
    assign bus.fifo_src      = !w_valid ? '0 : (r_out_state == OUT_IDLE) ? r_mem_src[w_ra] : r_hdr_src;
    assign bus.fifo_cmd      = !w_valid ? '0 : (r_out_state == OUT_IDLE) ? r_mem_cmd[w_ra] : r_hdr_cmd;

    always_ff @(posedge csclk) begin
        if (!srst_n) begin
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            pkt_cnt     <= '0;
            proto_err   <= 1'b0;
            r_hdr_src   <= '0;
            r_hdr_cmd   <= '0;
        end else begin
            r_in_state  <= w_in_state_nxt;
            r_out_state <= w_out_state_nxt;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_ONE;
            if (w_drop)  proto_err <= 1'b1;
            case ({w_wr_en & bus.in_eop, w_pop & w_head_eop})
                2'b10:   pkt_cnt <= pkt_cnt + c_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - c_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
            if ((r_out_state == OUT_IDLE) && w_pop) begin
                r_hdr_src <= r_mem_src[w_ra];
                r_hdr_cmd <= r_mem_cmd[w_ra];
            end
        end
    end

    always_ff @(posedge csclk) begin
        if (w_wr_en) begin
            r_mem_sop[w_wa]  <= bus.in_sop;
            r_mem_eop[w_wa]  <= bus.in_eop;
            r_mem_src[w_wa]  <= bus.in_src;
            r_mem_cmd[w_wa]  <= bus.in_cmd;
            r_mem_data[w_wa] <= bus.in_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ncbo_csi_txq.sv
`default_nettype none
// ============================================================================
// tb_ncbo_csi_txq : directed self-checking bench for ncbo_csi_txq
// Revision 1.0
// ============================================================================
module tb_ncbo_csi_txq;
    localparam int DEPTH  = 8;
    localparam int SRC_W  = 4;
    localparam int CMD_W  = 5;
    localparam int DATA_W = 64;

    logic       csclk = 1'b0;
    logic       srst_n;
    logic [3:0] pkt_cnt;
    logic       proto_err;
    int         n_asr  = 0;
    int         n_fail = 0;

    typedef struct {
        logic       rdy, pv, ps, pe;
        logic [3:0] psrc;
        logic [4:0] pcmd;
        logic [15:0] pd;
        logic       ev, es, ee;
        logic [3:0] esrc;
        logic [4:0] ecmd;
        logic [15:0] ed;
        logic [3:0] ep;
    } row_t;

    row_t rows [15];

    ncbo_csi_txq_if #(.SRC_W(SRC_W), .CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

    ncbo_csi_txq #(.DEPTH(DEPTH), .SRC_W(SRC_W), .CMD_W(CMD_W), .DATA_W(DATA_W)) dut (
        .csclk     (csclk),
        .srst_n    (srst_n),
        .bus       (bus),
        .pkt_cnt   (pkt_cnt),
        .proto_err (proto_err)
    );

    always #5 csclk = ~csclk;

    task automatic tick;
        @(posedge csclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asr++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic s, input logic e, input logic [3:0] src,
                        input logic [4:0] cmd, input logic [63:0] d);
        bus.in_val  = v;
        bus.in_sop  = s;
        bus.in_eop  = e;
        bus.in_src  = src;
        bus.in_cmd  = cmd;
        bus.in_data = d;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic s, input logic e,
                           input logic [3:0] src, input logic [4:0] cmd, input logic [63:0] d);
        chk({tag, "_val"},  64'(bus.val_tx_to_csi), 64'(v));
        chk({tag, "_sot"},  64'(bus.fifo_sot), 64'(s));
        chk({tag, "_eot"},  64'(bus.fifo_eot), 64'(e));
        chk({tag, "_src"},  64'(bus.fifo_src), 64'(src));
        chk({tag, "_cmd"},  64'(bus.fifo_cmd), 64'(cmd));
        chk({tag, "_data"}, bus.fifo_data, d);
    endtask

    task automatic chk_reset(input string tag);
        chk_out(tag, 1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk({tag, "_rdy"},  64'(bus.in_rdy), 64'd1);
        chk({tag, "_pkt"},  64'(pkt_cnt), 64'd0);
        chk({tag, "_perr"}, 64'(proto_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd6,  5'd10, 16'h500, 1'b1, 1'b1, 1'b0, 4'd1, 5'd1,  16'h400, 4'd1};
        rows[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  5'd2,  16'h600, 1'b1, 1'b1, 1'b0, 4'd1, 5'd1,  16'h400, 4'd2};
        rows[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 5'd31, 16'h601, 1'b1, 1'b0, 1'b1, 4'd1, 5'd1,  16'h401, 4'd2};
        rows[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b0, 1'b1, 4'd1, 5'd1,  16'h401, 4'd3};
        rows[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  5'd31, 16'h700, 1'b1, 1'b1, 1'b1, 4'd6, 5'd10, 16'h500, 4'd2};
        rows[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd8,  5'd3,  16'h800, 1'b1, 1'b1, 1'b1, 4'd6, 5'd10, 16'h500, 4'd3};
        rows[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b1, 1'b0, 4'd5, 5'd2,  16'h600, 4'd3};
        rows[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b1, 1'b0, 4'd5, 5'd2,  16'h600, 4'd3};
        rows[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b0, 1'b1, 4'd5, 5'd2,  16'h601, 4'd3};
        rows[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b0, 1'b1, 4'd5, 5'd2,  16'h601, 4'd3};
        rows[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b1, 1'b1, 4'd7, 5'd31, 16'h700, 4'd2};
        rows[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b1, 1'b1, 4'd7, 5'd31, 16'h700, 4'd2};
        rows[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b1, 1'b1, 4'd8, 5'd3,  16'h800, 4'd1};
        rows[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b1, 1'b1, 1'b1, 4'd8, 5'd3,  16'h800, 4'd1};
        rows[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  16'h0,   1'b0, 1'b0, 1'b0, 4'd0, 5'd0,  16'h0,   4'd0};

        srst_n      = 1'b0;
        bus.csi_rdy = 1'b0;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        tick;
        tick;
        chk_reset("rst");
        srst_n = 1'b1;

        // Single-beat packet: visible the cycle after its eop push
        push(1'b1, 1'b1, 1'b1, 4'd3, 5'd5, 64'hA5);
        tick;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk_out("single", 1'b1, 1'b1, 1'b1, 4'd3, 5'd5, 64'hA5);
        chk("single_pkt", 64'(pkt_cnt), 64'd1);
        bus.csi_rdy = 1'b1;
        tick;
        bus.csi_rdy = 1'b0;
        chk("single_pop_pkt", 64'(pkt_cnt), 64'd0);
        chk("single_pop_val", 64'(bus.val_tx_to_csi), 64'd0);

        // 4-beat packet, later beats carry junk src/cmd that must not appear
        bus.csi_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, i == 0, i == 3, (i == 0) ? 4'd9 : 4'hF, (i == 0) ? 5'h11 : 5'h1F, 64'(256 + i));
            chk("p4_noval", 64'(bus.val_tx_to_csi), 64'd0);
            tick;
        end
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk_out("p4_beat", 1'b1, i == 0, i == 3, 4'd9, 5'h11, 64'(256 + i));
            tick;
        end
        chk("p4_end_val", 64'(bus.val_tx_to_csi), 64'd0);
        chk("p4_end_pkt", 64'(pkt_cnt), 64'd0);

        // Fill without eop: cut-through, then finish the packet
        bus.csi_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, i == 0, 1'b0, (i == 0) ? 4'd2 : 4'hF, (i == 0) ? 5'd7 : 5'h1F, 64'(512 + i));
            tick;
        end
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk("fill_rdy", 64'(bus.in_rdy), 64'd0);
        chk("fill_pkt", 64'(pkt_cnt), 64'd0);
        chk_out("fill_ct", 1'b1, 1'b1, 1'b0, 4'd2, 5'd7, 64'h200);
        bus.csi_rdy = 1'b1;
        chk("fill_rdy_popcyc", 64'(bus.in_rdy), 64'd0);
        tick;
        bus.csi_rdy = 1'b0;
        chk("fill_rdy_after", 64'(bus.in_rdy), 64'd1);
        chk_out("fill_send", 1'b1, 1'b0, 1'b0, 4'd2, 5'd7, 64'h201);
        push(1'b1, 1'b0, 1'b1, 4'hF, 5'h1F, 64'h208);
        tick;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk("fill_eop_pkt", 64'(pkt_cnt), 64'd1);
        chk("fill_eop_rdy", 64'(bus.in_rdy), 64'd0);
        bus.csi_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk_out("fill_drain", 1'b1, 1'b0, i == 8, 4'd2, 5'd7, 64'(512 + i));
            tick;
        end
        bus.csi_rdy = 1'b0;
        chk("fill_end_val", 64'(bus.val_tx_to_csi), 64'd0);
        chk("fill_end_pkt", 64'(pkt_cnt), 64'd0);

        // Framing errors: stray non-sop beat, then sop inside a packet
        chk("perr_clear", 64'(proto_err), 64'd0);
        push(1'b1, 1'b0, 1'b1, 4'd1, 5'd1, 64'hDEAD);
        tick;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk("perr_set", 64'(proto_err), 64'd1);
        chk("perr_val", 64'(bus.val_tx_to_csi), 64'd0);
        chk("perr_pkt", 64'(pkt_cnt), 64'd0);
        push(1'b1, 1'b1, 1'b0, 4'd4, 5'd3, 64'h300);
        tick;
        push(1'b1, 1'b1, 1'b1, 4'd4, 5'd3, 64'hBAD);
        tick;
        chk("perr_mid_pkt", 64'(pkt_cnt), 64'd0);
        chk("perr_mid_val", 64'(bus.val_tx_to_csi), 64'd0);
        push(1'b1, 1'b0, 1'b1, 4'd4, 5'd3, 64'h301);
        tick;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk("perr_done_pkt", 64'(pkt_cnt), 64'd1);
        bus.csi_rdy = 1'b1;
        chk_out("perr_b0", 1'b1, 1'b1, 1'b0, 4'd4, 5'd3, 64'h300);
        tick;
        chk_out("perr_b1", 1'b1, 1'b0, 1'b1, 4'd4, 5'd3, 64'h301);
        tick;
        bus.csi_rdy = 1'b0;
        chk("perr_end_val", 64'(bus.val_tx_to_csi), 64'd0);
        chk("perr_sticky", 64'(proto_err), 64'd1);

        // Back-to-back packets with csi_rdy toggling each cycle
        push(1'b1, 1'b1, 1'b0, 4'd1, 5'd1, 64'h400);
        tick;
        push(1'b1, 1'b0, 1'b1, 4'hF, 5'h1F, 64'h401);
        tick;
        for (int r = 0; r < 15; r++) begin
            bus.csi_rdy = rows[r].rdy;
            push(rows[r].pv, rows[r].ps, rows[r].pe, rows[r].psrc, rows[r].pcmd, 64'(rows[r].pd));
            chk("b2b_val", 64'(bus.val_tx_to_csi), 64'(rows[r].ev));
            chk("b2b_pkt", 64'(pkt_cnt), 64'(rows[r].ep));
            if (rows[r].ev)
                chk_out("b2b", 1'b1, rows[r].es, rows[r].ee, rows[r].esrc, rows[r].ecmd, 64'(rows[r].ed));
            tick;
        end
        bus.csi_rdy = 1'b0;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);

        // Reset with two packets and a partial stored
        push(1'b1, 1'b1, 1'b1, 4'd1, 5'd1, 64'h900);
        tick;
        push(1'b1, 1'b1, 1'b1, 4'd2, 5'd2, 64'h901);
        tick;
        push(1'b1, 1'b1, 1'b0, 4'd3, 5'd3, 64'h902);
        tick;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk("prerst_pkt", 64'(pkt_cnt), 64'd2);
        srst_n = 1'b0;
        tick;
        chk_reset("midrst");
        srst_n = 1'b1;
        push(1'b1, 1'b1, 1'b0, 4'hC, 5'h15, 64'hA00);
        tick;
        push(1'b1, 1'b0, 1'b1, 4'hF, 5'h1F, 64'hA01);
        tick;
        push(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 64'h0);
        chk("postrst_pkt", 64'(pkt_cnt), 64'd1);
        chk_out("postrst_b0", 1'b1, 1'b1, 1'b0, 4'hC, 5'h15, 64'hA00);
        bus.csi_rdy = 1'b1;
        tick;
        chk_out("postrst_b1", 1'b1, 1'b0, 1'b1, 4'hC, 5'h15, 64'hA01);
        tick;
        bus.csi_rdy = 1'b0;
        chk("postrst_end_val", 64'(bus.val_tx_to_csi), 64'd0);
        chk("postrst_end_pkt", 64'(pkt_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ncbo_csi_txq.md
# ncbo_csi_txq

Store-and-forward packet queue between the NCB outbound request path and the CSI capture stage. It accepts multi-beat requests on a ready/valid push port and holds each one until its last beat arrives. It then presents the packet beat-by-beat as `fifo_*` fields with `val_tx_to_csi`, marking the first beat with `fifo_sot` so the downstream stage latches `csi.src`, `csi.wr` and `csi.cmd`.

## Interface

Parameters:
- DEPTH, 8: beat entries (power of 2, ≥2)
- SRC_W, 4: source id width
- CMD_W, 5: NCBO command width
- DATA_W, 64: payload width

Ports:
- csclk  in  1  clock
- srst_n  in  1  reset; synchronous, active-low
- in_val  in  1  push beat valid
- in_rdy  out  1  push ready
- in_sop  in  1  first beat of packet
- in_eop  in  1  last beat of packet (sop&eop = single-beat packet)
- in_src  in  SRC_W  source id (sampled on sop beat only)
- in_cmd  in  CMD_W  command (sampled on sop beat only)
- in_data  in  DATA_W  payload
- val_tx_to_csi  out  1  output beat valid
- csi_rdy  in  1  downstream accepts beat
- fifo_sot  out  1  output beat is first of packet
- fifo_eot  out  1  output beat is last of packet
- fifo_src  out  SRC_W  packet source id (held for all beats of packet)
- fifo_cmd  out  CMD_W  packet command (held for all beats)
- fifo_data  out  DATA_W  beat payload
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets resident
- proto_err  out  1  sticky framing error

## Operation

- Storage: DEPTH-entry circular buffer of {sop, eop, data}. Separate src/cmd header register per packet is not needed. src/cmd are stored in the sop entry and latched into output header regs when the sop beat is popped.
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits with a wrap bit. count = wr_ptr − rd_ptr.
- Push: fires when in_val & in_rdy. Condition: in_rdy = (count < DEPTH), computed from registered state only. A pop in the same cycle does not raise in_rdy.
- Input framing FSM, states IN_IDLE and IN_PKT:
  - IN_IDLE, push with sop: write beat. Go to IN_PKT unless eop.
  - IN_IDLE, push without sop: drop beat (in_rdy unaffected). Set proto_err.
  - IN_PKT, push with sop: drop beat. Set proto_err. Stay in IN_PKT.
  - IN_PKT, push with eop: write beat. Go to IN_IDLE.
- pkt_cnt: +1 on every written eop beat. −1 on every popped eop beat. Both in the same cycle → unchanged.
- Output FSM, states OUT_IDLE and OUT_SEND:
  - OUT_IDLE: val_tx_to_csi = (pkt_cnt>0) | (count==DEPTH). The second term is anti-deadlock cut-through for packets longer than DEPTH. Head entry presented with fifo_sot=1.
  - Pop of the sop beat without eop → OUT_SEND.
  - OUT_SEND: val_tx_to_csi = (count>0). Valid may bubble low mid-packet during cut-through. Pop of the eop beat → OUT_IDLE.
- Pop = val_tx_to_csi & csi_rdy.
- fifo_src/fifo_cmd: taken directly from the head entry on the sop beat. On later beats, taken from header regs loaded at sop pop.
- fifo_sot/fifo_eot/fifo_data: driven from the head entry (show-ahead). When val_tx_to_csi=0 they are don't-care but must not be X.

## Timing

- Reset (srst_n=0 at posedge): pointers, pkt_cnt and proto_err clear to 0; both FSMs go to IDLE; header regs clear to 0.
- Output values during reset: val_tx_to_csi=0, in_rdy=1, fifo_sot=0, fifo_eot=0, fifo_src=0, fifo_cmd=0, fifo_data=0.
- Reset mid-packet discards all stored beats. No partial packet is emitted afterwards.
- Latency: eop beat pushed at cycle N → val_tx_to_csi=1 at N+1 with sot beat presented.
- Throughput: one beat per cycle each side. Simultaneous push/pop at any count < DEPTH is legal.
- Downstream stall: while csi_rdy=0 with valid high, all fifo_* outputs hold stable.
- proto_err stays set until reset.

## Test plan

- Single-beat packet: push sop=eop=1, src=3, cmd=5, data=0xA5 at cycle 0 → cycle 1: val=1, sot=eot=1, src=3, cmd=5, data=0xA5, pkt_cnt=1. Pop → pkt_cnt=0, val=0.
- 4-beat packet, csi_rdy=1: no val until eop pushed. Then 4 consecutive beats. sot only on beat 0, eot only on beat 3. src/cmd constant across all 4.
- Fill: push 8 beats with no eop and no pop → in_rdy=0 at count 8. val asserts (cut-through). Pop 1 → in_rdy=1 next cycle. Finish with eop → clean drain.
- Framing errors: non-sop beat while idle → dropped, proto_err=1, count unchanged. Sop mid-packet → dropped, packet completes normally.
- Back-to-back packets with csi_rdy toggling 1/0 each cycle: outputs stable during stall. Every pkt_cnt transition is correct, including simultaneous eop push and eop pop.
- srst_n low for 1 cycle with 2 packets plus a partial stored → all outputs at reset values next cycle. A new packet afterwards emerges intact.
